// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one uart_tx among NUM_REQ byte streams.
// Optional lock timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_data_valid,
  input  logic                 tx_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCEPT, SEND, GAP} state_t;

  if (NUM_REQ < 1 || NUM_REQ > 8 || TIMEOUT < 2) begin : g_bad_params
    $error("uart_tx_arbiter: NUM_REQ must be 1..8 and TIMEOUT at least 2");
  end

  state_t            state_q, state_n;
  logic [7:0]        data_n;
  logic              valid_n;
  logic [NUM_REQ-1:0] grant_n;
  logic              lock_q, lock_n;
  logic [IW-1:0]     rr_q, rr_n;
  logic [IW-1:0]     owner_q, owner_n;
  logic              pick;
  logic [IW-1:0]     win;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_n;
`endif

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (int'(i) >= NUM_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  assign busy = (state_q != IDLE);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    state_n   = state_q;
    data_n    = tx_data;
    valid_n   = tx_data_valid;
    grant_n   = grant;
    lock_n    = lock_q;
    rr_n      = rr_q;
    owner_n   = owner_q;
    req_ready = '0;
    pick      = 1'b0;
    win       = '0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_n     = cnt_q;
`endif

    // A locked owner is the only candidate; otherwise search upward from rr_q with wrap.
    if (lock_q) begin
      pick = req_valid[owner_q];
      win  = owner_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!pick && req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
          pick = 1'b1;
          win  = IW'((int'(rr_q) + k) % NUM_REQ);
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (pick) begin
          req_ready[win] = rst_n;
          data_n         = req_data[int'(win)*8 +: 8];
          valid_n        = 1'b1;
          lock_n         = ~req_last[win];
          grant_n        = NUM_REQ'(1) << win;
          owner_n        = win;
          if (req_last[win]) rr_n = next_idx(win);
          state_n        = ACCEPT;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_n          = '0;
`endif
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (lock_q) begin
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            lock_n  = 1'b0;
            rr_n    = next_idx(owner_q);
            grant_n = '0;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
`endif
      end
      ACCEPT: state_n = SEND;
      SEND: begin
        // An ack already high here is genuine: GAP only exits after seeing it low.
        if (tx_ack) begin
          valid_n = 1'b0;
          state_n = GAP;
        end
      end
      GAP: begin
        if (!tx_ack) begin
          state_n = IDLE;
          if (!lock_q) grant_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!rst_n) begin
      state_q       <= IDLE;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
      grant         <= '0;
      lock_q        <= 1'b0;
      rr_q          <= '0;
      owner_q       <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_n;
      tx_data       <= data_n;
      tx_data_valid <= valid_n;
      grant         <= grant_n;
      lock_q        <= lock_n;
      rr_q          <= rr_n;
      owner_q       <= owner_n;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q         <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT=16).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_ack;
  logic [3:0]  grant;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_data_valid(tx_data_valid), .tx_ack(tx_ack), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input logic lvl, input string tag);
    int n = 0;
    while (tx_data_valid !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_data_valid !== lvl) begin
      failures++;
      $display("FAIL %s: tx_data_valid=%b after %0d cycles, required %b", tag, tx_data_valid, n, lvl);
    end
  endtask

  // Transmitter model: ack `delay` cycles after the data_valid rise, release once valid drops.
  task automatic ack_byte(input int delay);
    wait_valid(1'b1, "ack_rise");
    repeat (delay) @(negedge clk);
    tx_ack = 1'b1;
    @(negedge clk);
    wait_valid(1'b0, "ack_fall");
    tx_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'hF; req_data = 32'h44332211; req_last = 4'hF; tx_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({tx_data, tx_data_valid, grant, busy, req_ready} !== 18'd0) begin
      failures++;
      $display("FAIL reset_state: data=%h valid=%b grant=%b busy=%b ready=%b, required all zero",
               tx_data, tx_data_valid, grant, busy, req_ready);
    end
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_data_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: busy=%b valid=%b, required 0 0", busy, tx_data_valid);
    end
  endtask

  task automatic test_single();
    int extra = 0;
    int drop  = 0;
    do_reset();
    req_valid = 4'b0001; req_data[7:0] = 8'h55; req_last = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_ready: ready=%b, required 0001", req_ready);
    end
    @(negedge clk);
    checks++;
    if (tx_data_valid !== 1'b1 || tx_data !== 8'h55 || grant !== 4'b0001 || req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL single_accept: valid=%b data=%h grant=%b ready=%b, required 1 55 0001 0000",
               tx_data_valid, tx_data, grant, req_ready);
    end
    req_valid = '0;
    repeat (40) begin
      @(negedge clk);
      if (req_ready !== 4'b0000) extra++;
      if (tx_data_valid !== 1'b1) drop++;
    end
    checks++;
    if (extra != 0 || drop != 0) begin
      failures++;
      $display("FAIL single_hold: extra_ready=%0d valid_drops=%0d, required 0 0", extra, drop);
    end
    tx_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_data_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_ack_drop: valid=%b busy=%b, required 0 1", tx_data_valid, busy);
    end
    tx_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      failures++;
      $display("FAIL single_idle: busy=%b grant=%b, required 0 0000", busy, grant);
    end
  endtask

  task automatic test_round_robin();
    int low;
    do_reset();
    req_valid = 4'hF; req_data = 32'h13121110; req_last = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_valid(1'b1, "rr_rise");
      checks++;
      if (grant !== (4'b0001 << (k % 4)) || tx_data !== 8'(8'h10 + (k % 4))) begin
        failures++;
        $display("FAIL rr_order byte %0d: grant=%b data=%h, required %b %h",
                 k, grant, tx_data, 4'b0001 << (k % 4), 8'(8'h10 + (k % 4)));
      end
      if (k == 4) req_valid = '0;
      tx_ack = 1'b1;
      @(negedge clk);
      wait_valid(1'b0, "rr_fall");
      tx_ack = 1'b0;
      if (k < 4) begin
        low = 0;
        while (tx_data_valid === 1'b0 && low < 50) begin
          low++;
          @(negedge clk);
        end
        checks++;
        if (low < 2) begin
          failures++;
          $display("FAIL rr_gap byte %0d: valid low %0d cycles, required >= 2", k, low);
        end
      end
    end
  endtask

  task automatic test_message_lock();
    logic [7:0] exp_data [4];
    logic [3:0] exp_grant [4];
    exp_data  = '{8'hA1, 8'hA2, 8'hA3, 8'h0F};
    exp_grant = '{4'b0100, 4'b0100, 4'b0100, 4'b0001};
    do_reset();
    req_valid = 4'b0100; req_data[23:16] = 8'hA1; req_last = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      wait_valid(1'b1, "lock_rise");
      checks++;
      if (tx_data !== exp_data[k] || grant !== exp_grant[k]) begin
        failures++;
        $display("FAIL lock_order byte %0d: data=%h grant=%b, required %h %b",
                 k, tx_data, grant, exp_data[k], exp_grant[k]);
      end
      case (k)
        0: begin
          req_data[23:16] = 8'hA2;
          req_valid[0] = 1'b1; req_data[7:0] = 8'h0F; req_last[0] = 1'b1;
        end
        1: begin req_data[23:16] = 8'hA3; req_last[2] = 1'b1; end
        2: req_valid[2] = 1'b0;
        default: req_valid[0] = 1'b0;
      endcase
      tx_ack = 1'b1;
      @(negedge clk);
      wait_valid(1'b0, "lock_fall");
      tx_ack = 1'b0;
    end
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    req_valid = 4'b0100; req_data[23:16] = 8'h42; req_last = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    ack_byte(1);
    req_valid = 4'b0010; req_data[15:8] = 8'h21; req_last = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (tx_data !== 8'h21 || grant !== 4'b0010) begin
      failures++;
      $display("FAIL midrst_setup: data=%h grant=%b, required 21 0010", tx_data, grant);
    end
    req_valid = 4'b1011; req_data[7:0] = 8'h01; req_data[31:24] = 8'h03; req_last = 4'b1001;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_data, tx_data_valid, grant, busy, req_ready} !== 18'd0) begin
      failures++;
      $display("FAIL midrst_state: data=%h valid=%b grant=%b busy=%b ready=%b, required all zero",
               tx_data, tx_data_valid, grant, busy, req_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_rearb: ready=%b, required 0001", req_ready);
    end
    @(negedge clk);
    checks++;
    if (tx_data !== 8'h01 || grant !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_byte: data=%h grant=%b, required 01 0001", tx_data, grant);
    end
    req_valid = '0;
    ack_byte(1);
  endtask

  task automatic test_timeout();
    int k = 0;
    do_reset();
    req_valid = 4'b0010; req_data[15:8] = 8'h31; req_last = 4'b0000;
    @(negedge clk);
    req_valid = 4'b1000; req_data[31:24] = 8'h33; req_last = 4'b1000;
    ack_byte(2);
`ifdef UART_ARB_TIMEOUT_EN
    do begin
      @(negedge clk);
      k++;
    end while (req_ready[3] !== 1'b1 && k < 60);
    checks++;
    if (k != 17 || grant !== 4'b0000) begin
      failures++;
      $display("FAIL timeout_release: ready3 after %0d idle cycles grant=%b, required 17 0000", k, grant);
    end
    @(negedge clk);
    checks++;
    if (tx_data !== 8'h33 || grant !== 4'b1000) begin
      failures++;
      $display("FAIL timeout_grant: data=%h grant=%b, required 33 1000", tx_data, grant);
    end
    req_valid = '0;
    ack_byte(1);
`else
    repeat (40) begin
      @(negedge clk);
      if (req_ready !== 4'b0000) k++;
    end
    checks++;
    if (k != 0 || grant !== 4'b0010 || busy !== 1'b0) begin
      failures++;
      $display("FAIL lock_starve: ready_cycles=%0d grant=%b busy=%b, required 0 0010 0", k, grant, busy);
    end
    req_valid = '0;
`endif
  endtask

  task automatic test_long_ack();
    int bad = 0;
    do_reset();
    req_valid = 4'b0011; req_data[15:0] = 16'h7766; req_last = 4'b0011;
    wait_valid(1'b1, "longack_rise");
    checks++;
    if (tx_data !== 8'h66 || grant !== 4'b0001) begin
      failures++;
      $display("FAIL longack_first: data=%h grant=%b, required 66 0001", tx_data, grant);
    end
    tx_ack = 1'b1;
    @(negedge clk);
    wait_valid(1'b0, "longack_fall");
    repeat (5) begin
      @(negedge clk);
      if (req_ready !== 4'b0000 || busy !== 1'b1 || tx_data_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL longack_gap: %0d bad cycles while ack high, required 0", bad);
    end
    tx_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010 || busy !== 1'b0) begin
      failures++;
      $display("FAIL longack_next: ready=%b busy=%b, required 0010 0", req_ready, busy);
    end
    req_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_ack = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_message_lock();
    test_reset_mid_send();
    test_timeout();
    test_long_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
